i2c_target_regs: RTL and testbench

Synthesizable I2C target (responder) with a small byte register file, addressed by the DW8051 I2C master over the shared open-drain `i2c_sda`/`i2c_scl` bus. It sits beside or in place of the EEPROM model as the bus endpoint for the master IP. It decodes START/STOP, matches a 7-bit device address, and accepts a word-pointer byte. It then performs sequential writes or reads with pointer auto-increment. A local read port and write-strobe let surrounding logic observe the register contents.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_cond_detect.sv | 45 ++++
 rtl/i2c_target_regs.sv | 174 +++++++++++++++++
 tb/tb_i2c_target_regs.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target state encoding and ACK/NACK bus levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEVADR,
    ST_DEVACK,
    ST_PTR,
    ST_PTRACK,
    ST_WDAT,
    ST_WDACK,
    ST_RDAT,
    ST_RDACK
  } i2c_tstate_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_cond_detect.sv
// Bus input conditioning: 2-flop synchronizers, one history flop, registered
// SCL edge pulses and START/STOP detection (3 clk from pin to pulse).
module i2c_cond_detect (
  input  logic clk,
  input  logic rst_in,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hist;
  logic       sda_hist;

  assign sda = sda_sync[1];

  // Synchronize pins (idle-high on reset so no phantom edges) and register event pulses.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_hist  <= 1'b1;
      sda_hist  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[0], scl_in};
      sda_sync  <= {sda_sync[0], sda_in};
      scl_hist  <= scl_sync[1];
      sda_hist  <= sda_sync[1];
      scl_rise  <= scl_sync[1] & ~scl_hist;
      scl_fall  <= ~scl_sync[1] & scl_hist;
      start_det <= scl_sync[1] & scl_hist & sda_hist & ~sda_sync[1];
      stop_det  <= scl_sync[1] & scl_hist & ~sda_hist & sda_sync[1];
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register file: device-address match, word pointer,
// sequential writes/reads with pointer auto-increment, local read port.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned AW       = 4
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_pulse,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  import i2c_pkg::*;

  localparam int unsigned DEPTH = 2**AW;

  i2c_tstate_t   state;
  logic [7:0]    regs [DEPTH];
  logic [AW-1:0] ptr;
  logic [7:0]    rx;
  logic [7:0]    tx;
  logic [3:0]    bit_cnt;
  logic          rw;

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_cond_detect u_cond (
    .clk       (clk),
    .rst_in    (rst_in),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign host_rdata = regs[host_addr];

  // Protocol FSM: sample on SCL rise, change SDA drive on SCL fall, START/STOP override.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      sda_oe   <= 1'b0;
      ptr      <= '0;
      rx       <= '0;
      tx       <= '0;
      bit_cnt  <= '0;
      rw       <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (start_det) begin
        state   <= ST_DEVADR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_DEVADR, ST_PTR, ST_WDAT: begin
            if (bit_cnt != 4'd8) begin
              rx      <= {rx[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_RDAT: begin
            if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
          end
          ST_RDACK: begin
            if (sda_s == I2C_ACK) begin
              tx      <= regs[ptr];
              bit_cnt <= '0;
              state   <= ST_RDAT;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_DEVADR: begin
            if (bit_cnt == 4'd8) begin
              if (rx[7:1] == DEV_ADDR) begin
                state  <= ST_DEVACK;
                rw     <= rx[0];
                busy   <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_DEVACK: begin
            bit_cnt <= '0;
            if (rw) begin
              state  <= ST_RDAT;
              tx     <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
            end else begin
              state  <= ST_PTR;
              sda_oe <= 1'b0;
            end
          end
          ST_PTR: begin
            if (bit_cnt == 4'd8) begin
              ptr    <= rx[AW-1:0];
              sda_oe <= 1'b1;
              state  <= ST_PTRACK;
            end
          end
          ST_PTRACK, ST_WDACK: begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_WDAT;
          end
          ST_WDAT: begin
            if (bit_cnt == 4'd8) begin
              wr_pulse <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= rx;
              ptr      <= ptr + AW'(1);
              sda_oe   <= 1'b1;
              state    <= ST_WDACK;
            end
          end
          ST_RDAT: begin
            // bit_cnt==0 only after a master ACK reload: present MSB without shifting.
            if (bit_cnt == 4'd0) begin
              sda_oe <= ~tx[7];
            end else if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
              ptr    <= ptr + AW'(1);
              state  <= ST_RDACK;
            end else begin
              tx     <= {tx[6:0], 1'b0};
              sda_oe <= ~tx[6];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Register file: the commit strobe is registered, so the array updates the clk after wr_pulse.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_pulse) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, transaction-level memory
// model with expected-write queue, per-cycle compare of the local read port.
module tb_i2c_target_regs;

  import i2c_pkg::*;

  localparam int unsigned Q = 5;  // clk per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_in;
  logic       scl;
  logic       m_sda;
  logic       sda_line;
  logic       sda_oe;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_pulse;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda_line = m_sda & ~sda_oe;

  i2c_target_regs #(.DEV_ADDR(7'h50), .AW(4)) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .scl_in     (scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  mem [16];     // transaction-level register contents
  logic [7:0]  vis [16];     // contents visible on host port (after commit)
  int unsigned mptr;
  logic [11:0] exp_q [$];    // expected commits {addr, data}
  logic        hold = 1'b0;
  int          hi_cnt = 0;
  logic        prev_oe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: host port vs visible model, commits vs expected queue, SDA timing.
  always @(negedge clk) begin
    logic [11:0] e;
    logic        bad_edge;
    if (rst_in) begin
      for (int i = 0; i < 16; i++) vis[i] = 8'h00;
    end else begin
      check("host_rdata", {24'b0, host_rdata}, {24'b0, vis[host_addr]});
      if (wr_pulse) begin
        if (exp_q.size() == 0) begin
          check("wr_pulse with no write pending", {31'b0, wr_pulse}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {28'b0, wr_addr}, {28'b0, e[11:8]});
          check("wr_data", {24'b0, wr_data}, {24'b0, e[7:0]});
          vis[e[11:8]] = e[7:0];
        end
      end
    end
    if (sda_oe !== prev_oe) begin
      bad_edge = (hi_cnt >= 4);
      check("sda_oe changed while SCL high", {31'b0, bad_edge}, 32'd0);
    end
    prev_oe = sda_oe;
    if (scl) hi_cnt++; else hi_cnt = 0;
  end

  // Sweep the host read address so every location is compared over time.
  initial begin
    host_addr = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!hold) host_addr = host_addr + 4'd1;
    end
  end

  task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string name);
    hold = 1'b1;
    @(posedge clk);
    #1 host_addr = a;
    @(negedge clk);
    check(name, {24'b0, host_rdata}, {24'b0, exp});
    hold = 1'b0;
  endtask

  task automatic wq(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    wq(Q); m_sda = b;
    wq(Q); scl = 1'b1;
    wq(Q); s = sda_line;
    wq(Q); scl = 1'b0;
  endtask

  task automatic start_cond();
    wq(Q); m_sda = 1'b1;
    wq(Q); scl = 1'b1;
    wq(Q); m_sda = 1'b0;
    wq(Q); scl = 1'b0;
  endtask

  task automatic stop_cond();
    wq(Q); m_sda = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q); m_sda = 1'b1;
    wq(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_bit, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, s);
    check(name, {31'b0, s}, {31'b0, exp_bit});
  endtask

  task automatic recv_byte(input logic master_ack, input string name, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clock_bit(master_ack, s);
    check(name, {24'b0, d}, {24'b0, mem[mptr]});
    mptr = (mptr + 1) % 16;
  endtask

  task automatic bus_write(input logic [7:0] p, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] d;
    start_cond();
    send_byte(8'hA0, I2C_ACK, "ack on device address (write)");
    check("busy after address match", {31'b0, busy}, 32'd1);
    send_byte(p, I2C_ACK, "ack on pointer byte");
    mptr = p % 16;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : d1;
      exp_q.push_back({4'(mptr), d});
      mem[mptr] = d;
      mptr = (mptr + 1) % 16;
      send_byte(d, I2C_ACK, "ack on data byte");
    end
    stop_cond();
    check("busy after STOP", {31'b0, busy}, 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mptr = 0;
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [7:0] d;
    int         t;
    rst_in = 1'b1;
    scl    = 1'b1;
    m_sda  = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) vis[i] = 8'h00;
    repeat (4) @(negedge clk);
    check("reset sda_oe",   {31'b0, sda_oe},   32'd0);
    check("reset busy",     {31'b0, busy},     32'd0);
    check("reset wr_pulse", {31'b0, wr_pulse}, 32'd0);
    check("reset wr_addr",  {28'b0, wr_addr},  32'd0);
    check("reset wr_data",  {24'b0, wr_data},  32'd0);
    rst_in = 1'b0;
    wq(10);

    // Sequential write at pointer 3.
    bus_write(8'h03, 2, 8'h5A, 8'hC3);
    wq(4);
    check("writes outstanding after first write", exp_q.size(), 32'd0);
    peek(4'd3, 8'h5A, "regs[3] literal");
    peek(4'd4, 8'hC3, "regs[4] literal");

    // Random read: pointer write, repeated START, read two bytes.
    start_cond();
    send_byte(8'hA0, I2C_ACK, "ack on device address (rr)");
    send_byte(8'h03, I2C_ACK, "ack on pointer (rr)");
    mptr = 3;
    start_cond();
    send_byte(8'hA1, I2C_ACK, "ack on device address (read)");
    recv_byte(I2C_ACK, "read byte 0 vs model", d);
    check("read byte 0 literal", {24'b0, d}, 32'h5A);
    recv_byte(I2C_NACK, "read byte 1 vs model", d);
    check("read byte 1 literal", {24'b0, d}, 32'hC3);
    wq(2);
    check("busy after master NACK", {31'b0, busy}, 32'd0);
    check("sda released after NACK", {31'b0, sda_oe}, 32'd0);
    stop_cond();
    check("busy after STOP (rr)", {31'b0, busy}, 32'd0);

    // Address mismatch.
    start_cond();
    send_byte(8'hA2, I2C_NACK, "no ack on address mismatch");
    check("busy after mismatch", {31'b0, busy}, 32'd0);
    stop_cond();

    // Pointer wrap.
    bus_write(8'h0F, 2, 8'h11, 8'h22);
    wq(4);
    peek(4'd15, 8'h11, "wrap regs[15] literal");
    peek(4'd0,  8'h22, "wrap regs[0] literal");

    // STOP after 4 data bits: no commit.
    start_cond();
    send_byte(8'hA0, I2C_ACK, "ack on device address (partial)");
    send_byte(8'h05, I2C_ACK, "ack on pointer (partial)");
    mptr = 5;
    begin
      logic s;
      clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b0, s);
    end
    stop_cond();
    wq(4);
    peek(4'd5, 8'h00, "regs[5] untouched by aborted byte");
    bus_write(8'h00, 1, 8'h77, 8'h00);
    wq(4);
    peek(4'd0, 8'h77, "regs[0] after recovery write");

    // Reset while target drives a 0 data bit.
    start_cond();
    send_byte(8'hA0, I2C_ACK, "ack on device address (rst)");
    send_byte(8'h03, I2C_ACK, "ack on pointer (rst)");
    mptr = 3;
    start_cond();
    send_byte(8'hA1, I2C_ACK, "ack on device address (rst read)");
    t = 0;
    while (sda_oe !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("target driving 0 bit before reset", {31'b0, sda_oe}, 32'd1);
    rst_in = 1'b1;
    @(negedge clk);
    check("sda_oe released 1 clk after reset", {31'b0, sda_oe}, 32'd0);
    check("busy cleared by reset", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    model_reset();
    stop_cond();
    peek(4'd3, 8'h00, "regs[3] cleared by reset");
    start_cond();
    send_byte(8'hA1, I2C_ACK, "ack on device address (post-reset read)");
    recv_byte(I2C_NACK, "post-reset read vs model", d);
    check("post-reset read literal", {24'b0, d}, 32'h00);
    stop_cond();
    wq(4);
    check("writes outstanding at end", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
